// File: rtl/solver_pkg.sv
// Shared constants and types for the option scheduler and its queue RAM.
package solver_pkg;
    localparam int MAX_SIZE  = 11;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 7;
    localparam int DEPTH     = 512;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int NUM_LINES = 2 * MAX_SIZE;
    localparam int LINE_W    = $clog2(NUM_LINES);

    typedef struct packed {
        logic              is_header;
        logic [DATA_W-1:0] data;
    } queue_entry_t;

    typedef logic [2*MAX_SIZE-1:0][CNT_W-1:0] line_cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_START, ST_FETCH, ST_ISSUE, ST_WAIT, ST_WB, ST_DONE
    } state_t;
endpackage

// File: rtl/option_queue_ram.sv
// Simple dual-port queue storage: one write port, one read port, 1-cycle read latency.
module option_queue_ram
    import solver_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  queue_entry_t     wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output queue_entry_t     rd_data
);
    queue_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/option_scheduler.sv
// Circular option queue: loads per-line option lists, then streams them to the line
// solver round after round, requeueing kept options and counting down dropped ones.
module option_scheduler
    import solver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        num_rows,
    input  logic [3:0]        num_cols,
    input  logic              load_valid,
    input  logic              load_header,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              started,
    output logic [DATA_W-1:0] option,
    output logic              option_valid,
    output logic              option_is_header,
    output line_cnt_t         old_options_amnt,
    output logic [CNT_W-1:0]  all_options_remaining,
    input  logic              resp_valid,
    input  logic              put_back,
    input  logic              solved,
    input  logic              unsolvable,
    output logic              busy,
    output logic              done,
    output logic              stalled,
    output logic              error
);
    state_t            state, next_state;
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    occupancy;
    logic [LINE_W-1:0] cur_line;
    logic [4:0]        limit_q, line_limit;
    logic              have_header, keep_q, round_active, round_dropped, stalled_q, error_q;
    line_cnt_t         counts;
    logic [CNT_W-1:0]  total;
    queue_entry_t      rd_data, held, wr_data;
    logic              wr_en, rd_en, in_load, running, load_fire, load_err, load_ok;
    logic              zero_total, round_hdr, stall_det, terminate;
    logic              hdr_requeue, wb_keep, wb_drop;

    option_queue_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (tail),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (head),
        .rd_data (rd_data)
    );

    always_comb begin
        in_load    = (state == ST_IDLE) || (state == ST_LOAD);
        running    = state inside {ST_START, ST_FETCH, ST_ISSUE, ST_WAIT, ST_WB};
        load_ready = in_load && (occupancy != (PTR_W+1)'(DEPTH));
        // board size is taken from the pins only while the first entry is offered
        line_limit = (state == ST_IDLE) ? ({1'b0, num_rows} + {1'b0, num_cols}) : limit_q;
        load_fire  = in_load && load_valid;
        load_err   = load_fire && (!load_ready ||
                     (load_header ? ((load_data >= DATA_W'(line_limit)) ||
                                     (load_data >= DATA_W'(NUM_LINES)))
                                  : !have_header));
        zero_total = running && (total == '0);
        round_hdr  = (state == ST_ISSUE) && rd_data.is_header && (rd_data.data == '0);
        stall_det  = round_hdr && round_active && !round_dropped;
        terminate  = (state != ST_DONE) &&
                     (solved || unsolvable || zero_total || stall_det || load_err);

        load_ok     = load_fire && !terminate;
        hdr_requeue = (state == ST_ISSUE) && rd_data.is_header && !terminate;
        wb_keep     = (state == ST_WB) && keep_q && !terminate;
        wb_drop     = (state == ST_WB) && !keep_q && !terminate;
        rd_en       = (state == ST_FETCH) && !terminate;
        wr_en       = load_ok || hdr_requeue || wb_keep;
        wr_data     = held;
        if (load_ok)     wr_data = {load_header, load_data};
        if (hdr_requeue) wr_data = rd_data;

        started               = (state == ST_START);
        option_valid          = (state == ST_ISSUE);
        option                = option_valid ? rd_data.data : '0;
        option_is_header      = option_valid && rd_data.is_header;
        busy                  = (state != ST_IDLE) && (state != ST_DONE);
        done                  = (state == ST_DONE);
        stalled               = stalled_q;
        error                 = error_q;
        old_options_amnt      = counts;
        all_options_remaining = total;

        next_state = state;
        case (state)
            ST_IDLE, ST_LOAD: if (load_ok) next_state = load_last ? ST_START : ST_LOAD;
            ST_START:         next_state = ST_FETCH;
            ST_FETCH:         next_state = ST_ISSUE;
            ST_ISSUE:         next_state = rd_data.is_header ? ST_FETCH : ST_WAIT;
            ST_WAIT:          if (resp_valid) next_state = ST_WB;
            ST_WB:            next_state = ST_FETCH;
            ST_DONE:          next_state = ST_DONE;
            default:          next_state = ST_IDLE;
        endcase
        if (terminate) next_state = ST_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            occupancy     <= '0;
            cur_line      <= '0;
            limit_q       <= '0;
            have_header   <= 1'b0;
            keep_q        <= 1'b0;
            round_active  <= 1'b0;
            round_dropped <= 1'b0;
            stalled_q     <= 1'b0;
            error_q       <= 1'b0;
            counts        <= '0;
            total         <= '0;
            held          <= '0;
        end else begin
            if (rd_en) head <= head + 1'b1;
            if (wr_en) tail <= tail + 1'b1;
            occupancy <= occupancy + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
            if ((state == ST_IDLE) && load_ok) limit_q <= line_limit;
            if (load_ok && load_header) begin
                have_header <= 1'b1;
                cur_line    <= LINE_W'(load_data);
            end
            if (load_ok && !load_header) begin
                if (counts[cur_line] != '1) counts[cur_line] <= counts[cur_line] + 1'b1;
                if (total != '1)            total <= total + 1'b1;
            end
            if (state == ST_ISSUE) held <= rd_data;
            if (hdr_requeue) cur_line <= LINE_W'(rd_data.data);
            if (round_hdr && !terminate) begin
                round_active  <= 1'b1;
                round_dropped <= 1'b0;
            end
            if ((state == ST_WAIT) && resp_valid) keep_q <= put_back;
            if (wb_drop) begin
                if (counts[cur_line] != '0) counts[cur_line] <= counts[cur_line] - 1'b1;
                if (total != '0)            total <= total - 1'b1;
                round_dropped <= 1'b1;
            end
            if (stall_det) stalled_q <= 1'b1;
            if (load_err)  error_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_option_scheduler.sv
// Self-checking bench for option_scheduler: load tables, error table, queue-model runs.
`timescale 1ns/1ps
module tb_option_scheduler;
    import solver_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        num_rows, num_cols;
    logic              load_valid, load_header, load_last, load_ready, started;
    logic [DATA_W-1:0] load_data, option;
    logic              option_valid, option_is_header;
    line_cnt_t         old_options_amnt;
    logic [CNT_W-1:0]  all_options_remaining;
    logic              resp_valid, put_back, solved, unsolvable;
    logic              busy, done, stalled, error;

    always #5 clk = ~clk;

    option_scheduler dut (
        .clk                   (clk),
        .rst                   (rst),
        .num_rows              (num_rows),
        .num_cols              (num_cols),
        .load_valid            (load_valid),
        .load_header           (load_header),
        .load_data             (load_data),
        .load_last             (load_last),
        .load_ready            (load_ready),
        .started               (started),
        .option                (option),
        .option_valid          (option_valid),
        .option_is_header      (option_is_header),
        .old_options_amnt      (old_options_amnt),
        .all_options_remaining (all_options_remaining),
        .resp_valid            (resp_valid),
        .put_back              (put_back),
        .solved                (solved),
        .unsolvable            (unsolvable),
        .busy                  (busy),
        .done                  (done),
        .stalled               (stalled),
        .error                 (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic hdr; logic [DATA_W-1:0] data; } entry_t;
    typedef struct { int hdr; int data; int exp_total; } ld_vec_t;
    typedef struct { int rows; int cols; int hdr; int data; int exp_err; } err_vec_t;

    entry_t  ld_q[$];
    entry_t  m_q[$];
    int      m_cnt[NUM_LINES];
    int      m_total, m_cur;
    ld_vec_t  tbl3 [18];
    err_vec_t etbl [7];
    int       exp_cnt3 [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 0; load_header = 0; load_data = '0; load_last = 0;
        resp_valid = 0; put_back = 0; solved = 0; unsolvable = 0;
        num_rows = 4'd3; num_cols = 4'd3;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_3x3();
        entry_t e;
        num_rows = 4'd3; num_cols = 4'd3;
        ld_q.delete();
        for (int i = 0; i < 18; i++) begin
            load_valid  = 1'b1;
            load_header = (tbl3[i].hdr != 0);
            load_data   = DATA_W'(tbl3[i].data);
            load_last   = (i == 17);
            @(negedge clk);
            load_valid = 0; load_last = 0;
            check("load_total", all_options_remaining, tbl3[i].exp_total);
            e.hdr = (tbl3[i].hdr != 0); e.data = DATA_W'(tbl3[i].data);
            ld_q.push_back(e);
        end
        check("started_3x3", started, 1);
        for (int i = 0; i < 6; i++) check("load_count", old_options_amnt[i], exp_cnt3[i]);
    endtask

    task automatic load_queue();
        for (int i = 0; i < ld_q.size(); i++) begin
            load_valid  = 1'b1;
            load_header = ld_q[i].hdr;
            load_data   = ld_q[i].data;
            load_last   = (i == ld_q.size() - 1);
            @(negedge clk);
        end
        load_valid = 0; load_last = 0; load_header = 0;
        check("started", started, 1);
    endtask

    task automatic model_init();
        int cur = 0;
        m_q = ld_q;
        for (int i = 0; i < NUM_LINES; i++) m_cnt[i] = 0;
        m_total = 0; m_cur = 0;
        foreach (ld_q[i]) begin
            if (ld_q[i].hdr) cur = int'(ld_q[i].data);
            else begin m_cnt[cur]++; m_total++; end
        end
    endtask

    // mode 0: drop option 3 on line 0 only; 1: random verdicts; 2: drop everything
    task automatic run_solver(input int mode, input int budget);
        int     cyc = 0;
        int     d;
        bit     end_exp = 0, stall_exp = 0, round_on = 0, round_drop = 0, keep;
        entry_t e;
        while (!done && cyc < budget) begin
            if (option_valid) begin
                check("valid_while_ending", end_exp, 0);
                e = m_q.pop_front();
                check("option_word", option, e.data);
                check("option_is_header", option_is_header, e.hdr);
                if (e.hdr) begin
                    m_cur = int'(e.data);
                    if (m_cur == 0) begin
                        if (round_on && !round_drop) begin stall_exp = 1; end_exp = 1; end
                        round_on = 1; round_drop = 0;
                    end
                    m_q.push_back(e);
                    @(negedge clk); cyc++;
                end else begin
                    check("line_count", old_options_amnt[m_cur], m_cnt[m_cur]);
                    check("total", all_options_remaining, m_total);
                    case (mode)
                        0:       keep = !(m_cur == 0 && e.data == 3);
                        1:       keep = ($urandom_range(0, 3) != 0);
                        default: keep = 0;
                    endcase
                    resp_valid = (mode == 1) && ($urandom_range(0, 3) == 0);
                    put_back   = 0;
                    d = $urandom_range(1, 3);
                    repeat (d) begin @(negedge clk); resp_valid = 0; end
                    resp_valid = 1; put_back = keep;
                    @(negedge clk);
                    resp_valid = 0; put_back = 0;
                    cyc += d + 1;
                    if (keep) m_q.push_back(e);
                    else begin
                        m_cnt[m_cur]--; m_total--; round_drop = 1;
                        if (m_total == 0) end_exp = 1;
                    end
                end
            end else begin
                @(negedge clk); cyc++;
            end
        end
        check("done_reached", done, 1);
        check("model_expected_end", end_exp, 1);
        check("stalled", stalled, stall_exp);
        check("busy_after_done", busy, 0);
        check("final_total", all_options_remaining, m_total);
        for (int i = 0; i < NUM_LINES; i++) check("final_count", old_options_amnt[i], m_cnt[i]);
        repeat (4) begin
            @(negedge clk);
            check("no_valid_after_done", option_valid, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  sum;
        bit  found;
        entry_t e;
        tbl3 = '{'{1,0,0}, '{0,3,1}, '{0,6,2}, '{1,1,2}, '{0,1,3}, '{0,2,4}, '{0,4,5},
                 '{1,2,5}, '{0,5,6}, '{1,3,6}, '{0,1,7}, '{1,4,7}, '{0,2,8}, '{0,3,9},
                 '{1,5,9}, '{0,1,10}, '{0,2,11}, '{0,4,12}};
        exp_cnt3 = '{2, 3, 1, 1, 2, 3};
        etbl = '{'{3,3,0,5,1}, '{3,3,1,6,1}, '{3,3,1,5,0}, '{4,2,1,5,0},
                 '{11,11,1,21,0}, '{11,11,1,22,1}, '{1,1,1,2,1}};

        // reset state
        do_reset();
        check("rst_option_valid", option_valid, 0);
        check("rst_started", started, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stalled", stalled, 0);
        check("rst_error", error, 0);
        check("rst_total", all_options_remaining, 0);
        check("rst_load_ready", load_ready, 1);
        sum = 0;
        for (int i = 0; i < NUM_LINES; i++) sum += int'(old_options_amnt[i]);
        check("rst_counts", sum, 0);

        // 3x3 load, line 0 drops 011 then everything is kept -> stall
        load_3x3();
        @(negedge clk);
        check("started_one_cycle", started, 0);
        model_init();
        run_solver(0, 2000);
        check("row0_after_drop", old_options_amnt[0], 1);
        check("total_after_drop", all_options_remaining, 11);
        check("stall_flag", stalled, 1);

        // drop every option -> total reaches 0
        do_reset();
        load_3x3();
        model_init();
        run_solver(2, 2000);
        check("drain_total", all_options_remaining, 0);
        check("drain_done", done, 1);
        check("drain_stalled", stalled, 0);

        // solved together with a keep response
        do_reset();
        load_3x3();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (option_valid && !option_is_header) found = 1;
        end
        check("first_option_seen", found, 1);
        check("first_option_word", option, 3);
        @(negedge clk);
        resp_valid = 1; put_back = 1; solved = 1;
        @(negedge clk);
        resp_valid = 0; put_back = 0; solved = 0;
        check("solved_done", done, 1);
        check("solved_busy", busy, 0);
        check("solved_total", all_options_remaining, 12);
        check("solved_count0", old_options_amnt[0], 2);
        repeat (3) begin
            @(negedge clk);
            check("solved_no_valid", option_valid, 0);
        end

        // load protocol errors
        for (int i = 0; i < 7; i++) begin
            do_reset();
            num_rows = 4'(etbl[i].rows); num_cols = 4'(etbl[i].cols);
            load_valid = 1; load_header = (etbl[i].hdr != 0);
            load_data = DATA_W'(etbl[i].data); load_last = 0;
            @(negedge clk);
            load_valid = 0; load_header = 0;
            check("err_flag", error, etbl[i].exp_err);
            check("err_done", done, etbl[i].exp_err);
        end

        // fill the queue: counts saturate, then one more entry is an error
        do_reset();
        num_rows = 4'd1; num_cols = 4'd1;
        load_valid = 1; load_header = 1; load_data = '0; load_last = 0;
        @(negedge clk);
        load_header = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            load_data = DATA_W'(i);
            @(negedge clk);
        end
        load_valid = 0;
        check("full_not_ready", load_ready, 0);
        check("full_total_sat", all_options_remaining, 127);
        check("full_count_sat", old_options_amnt[0], 127);
        check("full_no_error_yet", error, 0);
        load_valid = 1;
        @(negedge clk);
        load_valid = 0;
        check("overflow_error", error, 1);
        check("overflow_done", done, 1);

        // randomized boards against the queue model
        for (int r = 0; r < 3; r++) begin
            int rows, cols, n;
            do_reset();
            rows = $urandom_range(1, 4); cols = $urandom_range(1, 4);
            num_rows = 4'(rows); num_cols = 4'(cols);
            ld_q.delete();
            for (int l = 0; l < rows + cols; l++) begin
                e.hdr = 1; e.data = DATA_W'(l);
                ld_q.push_back(e);
                n = (l == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    e.hdr = 0; e.data = DATA_W'($urandom_range(0, 65535));
                    ld_q.push_back(e);
                end
            end
            load_queue();
            model_init();
            check("rand_load_total", all_options_remaining, m_total);
            run_solver(1, 20000);
        end

        // asynchronous reset in the middle of a run
        do_reset();
        load_3x3();
        repeat (8) @(negedge clk);
        check("midrun_busy", busy, 1);
        #2 rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_valid", option_valid, 0);
        check("arst_option", option, 0);
        check("arst_total", all_options_remaining, 0);
        check("arst_count1", old_options_amnt[1], 0);
        check("arst_started", started, 0);
        check("arst_error", error, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_arst_busy", busy, 0);
        check("post_arst_total", all_options_remaining, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
